// File: rtl/wb_copy_pkg.sv
// wb_copy_pkg: shared FSM state type and bus constants for the Wishbone block-copy master
package wb_copy_pkg;
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, GAP, WR, WR_WAIT, FIN} wb_copy_state_t;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;
endpackage

// File: rtl/wb_copy_master_if.sv
// wb_copy_master_if: Wishbone B4 pipelined bus bundle with master/slave views
interface wb_copy_master_if #(parameter int AW = 28, parameter int DW = 32);
  logic cyc, stb, we, stall, ack, err;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w, dat_r;
  logic [3:0] sel;
  modport master(output cyc, stb, we, adr, dat_w, sel, input stall, ack, err, dat_r);
  modport slave(input cyc, stb, we, adr, dat_w, sel, output stall, ack, err, dat_r);
endinterface

// File: rtl/wb_copy_fifo.sv
// wb_copy_fifo: synchronous chunk buffer with push/pop/flush and full/empty flags
module wb_copy_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AWD = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AWD-1:0] wp, rp;
  logic [AWD:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AWD+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AWD'(do_push);
      rp <= rp + AWD'(do_pop);
      cnt <= cnt + (AWD+1)'(do_push) - (AWD+1)'(do_pop);
    end
endmodule

// File: rtl/wb_copy_master.sv
// wb_copy_master: chunked Wishbone block copy (read burst into buffer, write burst out); WB_COPY_TIMEOUT_EN adds an ack watchdog
module wb_copy_master
  import wb_copy_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int AW = 28,
  parameter int LEN_W = 16,
  parameter int BURST = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [AW-1:0] src_adr,
  input  logic [AW-1:0] dst_adr,
  input  logic [LEN_W-1:0] len,
  output logic busy,
  output logic done,
  output logic error,
  output logic [LEN_W-1:0] words_done,
  wb_copy_master_if.master wbm
);
  localparam int CW = $clog2(BURST + 1);
  if (DATA_WIDTH != 32 || BURST < 2 || (BURST & (BURST - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_copy_master: unsupported parameter set");
  end
  wb_copy_state_t state, state_n;
  logic [AW-1:0] src, dst;
  logic [LEN_W-1:0] rem, base;
  logic [CW-1:0] chunk, nchunk, req_cnt, ack_cnt;
  logic phase_wr, in_bus, accept, pending, ack_ok, bus_err, tmo_hit, last_req, last_ack;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  assign in_bus = state inside {RD, RD_WAIT, WR, WR_WAIT};
  assign wbm.cyc = in_bus;
  assign wbm.stb = state == RD || state == WR;
  assign wbm.we = state == WR || state == WR_WAIT;
  assign wbm.adr = state == RD ? src : state == WR ? dst : '0;
  assign wbm.dat_w = state == WR ? fifo_dout : '0;
  assign wbm.sel = wbm.stb ? WB_SEL_ALL : 4'h0;
  assign accept = wbm.stb && !wbm.stall;
  assign pending = req_cnt != ack_cnt;
  assign ack_ok = in_bus && wbm.ack && !wbm.err && pending;
  assign bus_err = in_bus && (wbm.err || tmo_hit);
  assign last_req = accept && req_cnt + 1'b1 == chunk;
  assign last_ack = ack_ok && ack_cnt + 1'b1 == chunk;
  assign base = state == IDLE ? len : rem;
  assign nchunk = base >= LEN_W'(BURST) ? CW'(BURST) : CW'(base);
  assign fifo_push = ack_ok && !phase_wr && !fifo_full;
  assign fifo_pop = state == WR && accept && !fifo_empty;
  assign busy = state != IDLE;
  assign done = state == FIN;
`ifdef WB_COPY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic tmo_run;
  // The accepting cycle already counts as waiting, so the abort lands TIMEOUT_CYCLES after the request.
  assign tmo_run = in_bus && (pending || accept) && !wbm.ack;
  assign tmo_hit = tmo_run && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  // Watchdog: counts ack-less waiting cycles, cleared by any ack or idle bus.
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_cnt <= '0;
    else tmo_cnt <= tmo_run ? tmo_cnt + 1'b1 : '0;
`else
  assign tmo_hit = 1'b0;
`endif
  wb_copy_fifo #(.DEPTH(BURST), .W(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(fifo_push),
    .pop(fifo_pop),
    .flush(bus_err),
    .din(wbm.dat_r),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  // FSM state register.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Next state: chunk phases separated by a one-cycle GAP; any bus error aborts to FIN.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = len == '0 ? FIN : RD;
      RD: if (last_req) state_n = RD_WAIT;
      RD_WAIT: if (last_ack) state_n = GAP;
      GAP: state_n = !phase_wr ? WR : rem != '0 ? RD : FIN;
      WR: if (last_req) state_n = WR_WAIT;
      WR_WAIT: if (last_ack) state_n = GAP;
      default: state_n = IDLE;
    endcase
    if (bus_err) state_n = FIN;
  end
  // Datapath: addresses, chunk bookkeeping, per-phase request/ack counters and status.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      src <= '0;
      dst <= '0;
      rem <= '0;
      chunk <= '0;
      req_cnt <= '0;
      ack_cnt <= '0;
      phase_wr <= 1'b0;
      error <= 1'b0;
      words_done <= '0;
    end else begin
      if (state == IDLE && start) begin
        src <= src_adr;
        dst <= dst_adr;
        rem <= len - LEN_W'(nchunk);
        chunk <= nchunk;
        phase_wr <= 1'b0;
        error <= 1'b0;
        words_done <= '0;
      end
      if (state == GAP) phase_wr <= !phase_wr;
      if (state == GAP && phase_wr && rem != '0) begin
        chunk <= nchunk;
        rem <= rem - LEN_W'(nchunk);
      end
      if (state == RD && accept) src <= src + 1'b1;
      if (state == WR && accept) dst <= dst + 1'b1;
      req_cnt <= in_bus ? req_cnt + CW'(accept) : '0;
      ack_cnt <= in_bus ? ack_cnt + CW'(ack_ok) : '0;
      if (ack_ok && phase_wr) words_done <= words_done + 1'b1;
      if (bus_err) error <= 1'b1;
    end
endmodule

// File: tb/tb_wb_copy_master.sv
// tb_wb_copy_master: directed self-checking bench with a pipelined Wishbone slave model
module tb_wb_copy_master;
  logic clk = 1'b0;
  logic rst, start, busy, done, error;
  logic [27:0] src, dst;
  logic [15:0] len, words_done;
  wb_copy_master_if #(.AW(28)) bus();
  wb_copy_master #(.BURST(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src_adr(src), .dst_adr(dst), .len(len),
    .busy(busy), .done(done), .error(error), .words_done(words_done), .wbm(bus.master)
  );
  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  logic [31:0] mem [logic [27:0]];
  bit no_ack, use_stall;
  int err_at;
  bit [6:0] stall_pat = 7'b0100110;
  bit pend_v, pend_we, hold, prev_cyc;
  logic [27:0] pend_adr, h_adr;
  logic [31:0] pend_dat, h_dat;
  int ph, wr_cnt, low_run, run_acc, stall_viol, proto_viol, stall_hits;
  int chunk_log[$], gap_log[$];

  // Slave model and bus monitor: responses one cycle after acceptance, driven at negedge.
  always @(negedge clk) begin
    bus.ack = 1'b0;
    bus.err = 1'b0;
    bus.dat_r = '0;
    if (pend_v && !no_ack) begin
      if (pend_we) begin
        wr_cnt++;
        if (wr_cnt == err_at) bus.err = 1'b1;
        else begin bus.ack = 1'b1; mem[pend_adr] = pend_dat; end
      end else begin
        bus.ack = 1'b1;
        bus.dat_r = mem.exists(pend_adr) ? mem[pend_adr] : 32'hDEAD0000;
      end
    end
    bus.stall = use_stall && stall_pat[ph % 7];
    ph++;
    if (hold && (!bus.stb || bus.adr !== h_adr || (bus.we && bus.dat_w !== h_dat))) stall_viol++;
    hold = bus.stb && bus.stall;
    if (hold) stall_hits++;
    h_adr = bus.adr;
    h_dat = bus.dat_w;
    if ((bus.stb && !bus.cyc) || bus.sel !== (bus.stb ? 4'hF : 4'h0)) proto_viol++;
    pend_v = bus.cyc && bus.stb && !bus.stall;
    pend_we = bus.we;
    pend_adr = bus.adr;
    pend_dat = bus.dat_w;
    if (bus.cyc) begin
      if (!prev_cyc) gap_log.push_back(low_run);
      low_run = 0;
      if (pend_v) run_acc++;
    end else begin
      if (prev_cyc) begin chunk_log.push_back(run_acc); run_acc = 0; end
      low_run++;
    end
    prev_cyc = bus.cyc;
  end

  task automatic issue(input logic [27:0] s, input logic [27:0] d, input logic [15:0] l);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      if (done) ok = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [104:0] z = '0;
    compared++;
    if ({busy, done, error, words_done, bus.cyc, bus.stb, bus.we, bus.adr, bus.dat_w, bus.sel} !== z) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0", {busy, done, error, words_done, bus.cyc, bus.stb, bus.we, bus.adr, bus.dat_w, bus.sel});
    end
  endtask

  task automatic test_basic;
    logic [31:0] cyc_obs = '0, done_obs = '0;
    logic b1;
    int bad = 0;
    for (int i = 0; i < 4; i++) mem[28'h100 + 28'(i)] = 32'hA5A50000 + 32'(i * 3);
    issue(28'h100, 28'h200, 16'd4);
    b1 = busy;
    for (int c = 1; c <= 20; c++) begin
      cyc_obs[c] = bus.cyc;
      done_obs[c] = done;
      @(negedge clk);
    end
    compared++;
    if (cyc_obs !== 32'h00000FBE) begin mismatched++; $display("FAIL basic_cyc_timing: got %h want 00000fbe", cyc_obs); end
    compared++;
    if (done_obs !== 32'h00002000) begin mismatched++; $display("FAIL basic_done_cycle: got %h want 00002000", done_obs); end
    compared++;
    if (b1 !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy: got %b/%b want 1/0", b1, busy); end
    compared++;
    if (words_done !== 16'd4 || error !== 1'b0) begin mismatched++; $display("FAIL basic_status: words_done %0d error %b want 4 0", words_done, error); end
    for (int i = 0; i < 4; i++)
      if (!mem.exists(28'h200 + 28'(i)) || mem[28'h200 + 28'(i)] !== 32'hA5A50000 + 32'(i * 3)) bad++;
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL basic_data: %0d bad words want 0", bad); end
  endtask

  task automatic test_multi;
    int n0 = chunk_log.size(), g0 = gap_log.size(), sv0 = stall_viol, sh0 = stall_hits;
    int exp_ch[6] = '{8, 8, 8, 8, 4, 4};
    int bad = 0;
    bit ok;
    for (int i = 0; i < 20; i++) mem[28'h1000 + 28'(i)] = 32'h5EED0000 ^ 32'(i * 32'h01010101);
    use_stall = 1'b1;
    issue(28'h1000, 28'h2000, 16'd20);
    wait_done(400, ok);
    use_stall = 1'b0;
    @(negedge clk);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL multi_done: no done within 400 cycles"); end
    compared++;
    if (chunk_log.size() != n0 + 6) begin
      mismatched++;
      $display("FAIL multi_chunk_count: got %0d phases want 6", chunk_log.size() - n0);
    end else
      for (int i = 0; i < 6; i++) begin
        compared++;
        if (chunk_log[n0 + i] != exp_ch[i]) begin mismatched++; $display("FAIL multi_chunk_%0d: got %0d want %0d", i, chunk_log[n0 + i], exp_ch[i]); end
      end
    for (int i = g0 + 1; i < gap_log.size(); i++) if (gap_log[i] != 1) bad++;
    compared++;
    if (bad != 0 || gap_log.size() != g0 + 6) begin mismatched++; $display("FAIL multi_gaps: %0d bad gaps of %0d want 0 of 5", bad, gap_log.size() - g0 - 1); end
    compared++;
    if (stall_viol != sv0 || stall_hits == sh0) begin mismatched++; $display("FAIL multi_stall_hold: violations %0d stalls %0d want 0 and >0", stall_viol - sv0, stall_hits - sh0); end
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (!mem.exists(28'h2000 + 28'(i)) || mem[28'h2000 + 28'(i)] !== (32'h5EED0000 ^ 32'(i * 32'h01010101))) bad++;
    compared++;
    if (bad != 0 || words_done !== 16'd20) begin mismatched++; $display("FAIL multi_data: %0d bad words, words_done %0d want 0 and 20", bad, words_done); end
  endtask

  task automatic test_zero_len;
    logic d1, d2;
    bit seen = 1'b0;
    issue(28'h100, 28'h300, 16'd0);
    d1 = done;
    for (int c = 1; c <= 5; c++) begin
      if (bus.cyc) seen = 1'b1;
      @(negedge clk);
      if (c == 1) d2 = done;
    end
    compared++;
    if (d1 !== 1'b1 || d2 !== 1'b0) begin mismatched++; $display("FAIL zero_done: got %b%b want 10", d1, d2); end
    compared++;
    if (seen || words_done !== 16'd0) begin mismatched++; $display("FAIL zero_bus: cyc seen %b words_done %0d want 0 0", seen, words_done); end
  endtask

  task automatic test_write_error;
    logic [31:0] cyc_obs = '0, done_obs = '0;
    logic e1;
    bit ok;
    for (int i = 0; i < 8; i++) mem[28'h3000 + 28'(i)] = 32'hC0DE0000 + 32'(i);
    err_at = wr_cnt + 3;
    issue(28'h3000, 28'h4000, 16'd8);
    for (int c = 1; c <= 20; c++) begin
      cyc_obs[c] = bus.cyc;
      done_obs[c] = done;
      @(negedge clk);
    end
    compared++;
    if (cyc_obs !== 32'h00007BFE) begin mismatched++; $display("FAIL werr_cyc_timing: got %h want 00007bfe", cyc_obs); end
    compared++;
    if (done_obs !== 32'h00008000) begin mismatched++; $display("FAIL werr_done_cycle: got %h want 00008000", done_obs); end
    compared++;
    if (error !== 1'b1 || words_done !== 16'd2) begin mismatched++; $display("FAIL werr_status: error %b words_done %0d want 1 2", error, words_done); end
    issue(28'h3000, 28'h5000, 16'd1);
    e1 = error;
    wait_done(50, ok);
    compared++;
    if (e1 !== 1'b0 || !ok) begin mismatched++; $display("FAIL werr_restart: error %b done %b want 0 1", e1, ok); end
    compared++;
    if (!mem.exists(28'h5000) || mem[28'h5000] !== 32'hC0DE0000) begin mismatched++; $display("FAIL werr_flush: got %h want c0de0000", mem.exists(28'h5000) ? mem[28'h5000] : 32'hx); end
  endtask

  task automatic test_timeout_busy;
    logic [31:0] cyc_obs = '0, done_obs = '0;
    no_ack = 1'b1;
    issue(28'h6000, 28'h7000, 16'd1);
    for (int c = 1; c <= 24; c++) begin
      cyc_obs[c] = bus.cyc;
      done_obs[c] = done;
      if (c == 3) begin src = 28'h6100; len = 16'd5; start = 1'b1; end
      @(negedge clk);
      start = 1'b0;
    end
`ifdef WB_COPY_TIMEOUT_EN
    compared++;
    if (cyc_obs !== 32'h0001FFFE) begin mismatched++; $display("FAIL tmo_cyc_timing: got %h want 0001fffe", cyc_obs); end
    compared++;
    if (done_obs !== 32'h00020000) begin mismatched++; $display("FAIL tmo_done_cycle: got %h want 00020000", done_obs); end
    compared++;
    if (error !== 1'b1 || busy !== 1'b0 || words_done !== 16'd0) begin mismatched++; $display("FAIL tmo_status: error %b busy %b words_done %0d want 1 0 0", error, busy, words_done); end
`else
    compared++;
    if (cyc_obs !== 32'h01FFFFFE || done_obs !== 32'h0) begin mismatched++; $display("FAIL nowd_wait: cyc %h done %h want 01fffffe 0", cyc_obs, done_obs); end
    compared++;
    if (busy !== 1'b1 || error !== 1'b0) begin mismatched++; $display("FAIL nowd_status: busy %b error %b want 1 0", busy, error); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    no_ack = 1'b0;
  endtask

  task automatic test_reset_wrap;
    logic [104:0] z = '0;
    logic [31:0] done_obs = '0;
    logic [27:0] adr3 = '1;
    int bad = 0;
    no_ack = 1'b1;
    issue(28'h100, 28'h200, 16'd4);
    repeat (5) @(negedge clk);
    compared++;
    if (bus.cyc !== 1'b1 || bus.stb !== 1'b0) begin mismatched++; $display("FAIL rw_in_rd_wait: cyc %b stb %b want 1 0", bus.cyc, bus.stb); end
    #1 rst = 1'b1;
    #1;
    compared++;
    if ({busy, done, error, words_done, bus.cyc, bus.stb, bus.we, bus.adr, bus.dat_w, bus.sel} !== z) begin
      mismatched++;
      $display("FAIL rw_async_reset: got %h want 0", {busy, done, error, words_done, bus.cyc, bus.stb, bus.we, bus.adr, bus.dat_w, bus.sel});
    end
    @(negedge clk);
    rst = 1'b0;
    no_ack = 1'b0;
    mem[28'hFFFFFFE] = 32'h11110000;
    mem[28'hFFFFFFF] = 32'h22220000;
    mem[28'h0000000] = 32'h33330000;
    mem[28'h0000001] = 32'h44440000;
    issue(28'hFFFFFFE, 28'h800, 16'd4);
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) adr3 = bus.adr;
      done_obs[c] = done;
      @(negedge clk);
    end
    compared++;
    if (adr3 !== 28'h0) begin mismatched++; $display("FAIL rw_wrap_adr: got %h want 0000000", adr3); end
    compared++;
    if (done_obs !== 32'h00002000 || words_done !== 16'd4 || error !== 1'b0) begin mismatched++; $display("FAIL rw_complete: done %h words_done %0d error %b want 00002000 4 0", done_obs, words_done, error); end
    for (int i = 0; i < 4; i++)
      if (!mem.exists(28'h800 + 28'(i)) || mem[28'h800 + 28'(i)] !== 32'(i + 1) * 32'h11110000) bad++;
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL rw_data: %0d bad words want 0", bad); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    no_ack = 1'b0; use_stall = 1'b0; err_at = 0;
    #2 test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_multi();
    test_zero_len();
    test_write_error();
    test_timeout_busy();
    test_reset_wrap();
    compared++;
    if (proto_viol != 0) begin mismatched++; $display("FAIL protocol_sel_stb: %0d violations want 0", proto_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
